// File: rtl/rd1_trace_recorder.sv
// Records register-file Rd1 samples with sequence numbers into a FIFO trace buffer.
// Readout is a valid/ready stream that may overlap recording; excess samples are counted as dropped.
module rd1_trace_recorder #(
  parameter int unsigned BIT_COUNT = 64,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     sample_valid,
  input  logic [BIT_COUNT-1:0]     rd1,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BIT_COUNT-1:0]     out_data,
  output logic [31:0]              out_index,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [31:0]              dropped,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRecord, StDrain} state_e;

  state_e               state_q;
  logic [BIT_COUNT-1:0] data_mem_q [DEPTH];
  logic [31:0]          idx_mem_q  [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q, count_d;
  logic [31:0]          seq_q, dropped_q;
  logic                 overflow_q;
  logic                 pop, capture, push, drop;

  always_comb begin
    pop     = (count_q != '0) && out_ready;
    capture = (state_q == StRecord) && sample_valid;
    // A full buffer still accepts a sample when the head leaves on the same edge.
    push    = capture && ((count_q != FullCount) || pop);
    drop    = capture && !push;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset && push) begin
      data_mem_q[wr_ptr_q] <= rd1;
      idx_mem_q[wr_ptr_q]  <= seq_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      dropped_q  <= '0;
    end else begin
      if (push)    wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (capture) seq_q    <= seq_q + 32'd1;
      if (drop) begin
        overflow_q <= 1'b1;
        if (dropped_q != 32'hFFFF_FFFF) dropped_q <= dropped_q + 32'd1;
      end
      count_q <= count_d;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StRecord;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
          end
        end
        StRecord: if (stop) state_q <= StDrain;
        StDrain:  if (count_d == '0) state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    out_valid = (count_q != '0);
    out_data  = out_valid ? data_mem_q[rd_ptr_q] : '0;
    out_index = out_valid ? idx_mem_q[rd_ptr_q] : '0;
    count     = count_q;
    overflow  = overflow_q;
    dropped   = dropped_q;
    busy      = (state_q != StIdle);
  end

endmodule

// File: tb/tb_rd1_trace_recorder.sv
// Bench for rd1_trace_recorder: vector table, directed corner sequences and a randomized run
// checked against a queue-based reference model.
module tb_rd1_trace_recorder;

  localparam int unsigned BW = 64;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0, stop = 1'b0, sample_valid = 1'b0, out_ready = 1'b0;
  logic [BW-1:0] rd1 = '0;
  logic          out_valid, overflow, busy;
  logic [BW-1:0] out_data;
  logic [31:0]   out_index, dropped;
  logic [4:0]    count;

  int checks = 0;
  int errors = 0;

  rd1_trace_recorder #(.BIT_COUNT(BW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .sample_valid(sample_valid),
    .rd1(rd1), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .count(count), .overflow(overflow), .dropped(dropped), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of (sequence number, value) plus a mode number.
  typedef struct {logic [31:0] idx; logic [BW-1:0] data;} ent_t;
  ent_t        mq[$];
  logic [31:0] mseq = '0, mdrop = '0;
  logic        movf = 1'b0;
  int          mmode = 0; // 0 idle, 1 recording, 2 draining

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rs, st, sp, sv, input logic [BW-1:0] d,
                            input logic rdy);
    bit pop, full, cap;
    if (!rs) begin
      mq.delete(); mseq = '0; movf = 1'b0; mdrop = '0; mmode = 0;
      return;
    end
    pop  = (mq.size() != 0) && rdy;
    full = (mq.size() == DEPTH);
    cap  = (mmode == 1) && sv;
    if (pop) void'(mq.pop_front());
    if (cap) begin
      if (!full || pop) mq.push_back('{idx: mseq, data: d});
      else begin
        movf = 1'b1;
        if (mdrop != 32'hFFFF_FFFF) mdrop = mdrop + 1;
      end
      mseq = mseq + 1;
    end
    case (mmode)
      0: if (st) begin
        mq.delete(); mseq = '0; movf = 1'b0; mdrop = '0; mmode = 1;
      end
      1: if (sp) mmode = 2;
      default: if (mq.size() == 0) mmode = 0;
    endcase
  endtask

  task automatic compare_model();
    bit v;
    v = (mq.size() != 0);
    chk("m_out_valid", out_valid, v);
    chk("m_out_data",  out_data,  v ? mq[0].data : '0);
    chk("m_out_index", out_index, v ? mq[0].idx : '0);
    chk("m_count",     count,     mq.size());
    chk("m_overflow",  overflow,  movf);
    chk("m_dropped",   dropped,   mdrop);
    chk("m_busy",      busy,      mmode != 0);
  endtask

  // Called at a negedge: drive inputs, advance model, cross one rising edge, compare.
  task automatic cycle(input logic rs, st, sp, sv, input logic [BW-1:0] d, input logic rdy);
    reset = rs; start = st; stop = sp; sample_valid = sv; rd1 = d; out_ready = rdy;
    model_step(rs, st, sp, sv, d, rdy);
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  typedef struct {
    logic rs, st, sp, sv; logic [BW-1:0] d; logic rdy;
    logic ev; logic [31:0] ei; logic [BW-1:0] ed; logic [4:0] ec; logic eb;
  } vec_t;
  vec_t tbl[11];

  initial begin
    // rs st sp sv data rdy | valid index data count busy (after the edge)
    tbl[0]  = '{1'b0, 0, 0, 0, 64'h00, 0,  0, 0, 64'h00, 0, 0};
    tbl[1]  = '{1'b1, 1, 0, 0, 64'h00, 1,  0, 0, 64'h00, 0, 1};
    tbl[2]  = '{1'b1, 0, 0, 1, 64'h11, 1,  1, 0, 64'h11, 1, 1};
    tbl[3]  = '{1'b1, 0, 0, 1, 64'h22, 1,  1, 1, 64'h22, 1, 1};
    tbl[4]  = '{1'b1, 1, 0, 1, 64'h33, 1,  1, 2, 64'h33, 1, 1};
    tbl[5]  = '{1'b1, 0, 0, 0, 64'h00, 1,  0, 0, 64'h00, 0, 1};
    tbl[6]  = '{1'b1, 0, 1, 0, 64'h00, 1,  0, 0, 64'h00, 0, 1};
    tbl[7]  = '{1'b1, 0, 0, 0, 64'h00, 1,  0, 0, 64'h00, 0, 0};
    tbl[8]  = '{1'b1, 1, 1, 0, 64'h00, 1,  0, 0, 64'h00, 0, 1};
    tbl[9]  = '{1'b1, 1, 1, 0, 64'h00, 1,  0, 0, 64'h00, 0, 1};
    tbl[10] = '{1'b1, 0, 0, 0, 64'h00, 1,  0, 0, 64'h00, 0, 0};

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].rs, tbl[i].st, tbl[i].sp, tbl[i].sv, tbl[i].d, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_index", i), out_index, tbl[i].ei);
      chk($sformatf("tbl%0d_data", i),  out_data,  tbl[i].ed);
      chk($sformatf("tbl%0d_count", i), count,     tbl[i].ec);
      chk($sformatf("tbl%0d_busy", i),  busy,      tbl[i].eb);
    end

    // Overflow: 20 samples into 16 entries with no readout.
    cycle(0, 0, 0, 0, '0, 0);
    cycle(1, 1, 0, 0, '0, 0);
    for (int i = 0; i < 20; i++) cycle(1, 0, 0, 1, {$urandom, $urandom}, 0);
    chk("ovf_count", count, 16);
    chk("ovf_dropped", dropped, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", out_index, 0);
    cycle(1, 0, 1, 0, '0, 0);
    for (int k = 0; k < 16; k++) begin
      chk("drain_idx", out_index, k);
      cycle(1, 0, 0, 0, '0, 1);
    end
    chk("drain_done_busy", busy, 0);
    chk("drain_done_valid", out_valid, 0);

    // Full buffer with simultaneous pop and push.
    cycle(1, 1, 0, 0, '0, 0);
    for (int i = 0; i < 16; i++) cycle(1, 0, 0, 1, {$urandom, $urandom}, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 1, {$urandom, $urandom}, 1);
    chk("fullpop_count", count, 16);
    chk("fullpop_dropped", dropped, 0);
    chk("fullpop_head", out_index, 5);

    // Backpressure during readout: ready 1,0,0,1.
    cycle(1, 0, 1, 0, '0, 0);
    cycle(1, 0, 0, 0, '0, 1);
    chk("bp_pop1", out_index, 6);
    cycle(1, 0, 0, 0, '0, 0);
    chk("bp_hold1", out_index, 6);
    cycle(1, 0, 0, 0, '0, 0);
    chk("bp_hold2", out_index, 6);
    cycle(1, 0, 0, 0, '0, 1);
    chk("bp_pop2", out_index, 7);
    begin
      int budget = 40;
      while (busy && budget > 0) begin
        cycle(1, 0, 0, 0, '0, 1);
        budget--;
      end
      chk("bp_drain_timeout", budget > 0, 1);
    end

    // Reset in the middle of recording.
    cycle(1, 1, 0, 0, '0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 1, {$urandom, $urandom}, 0);
    chk("rst_pre_count", count, 5);
    cycle(0, 0, 0, 1, 64'hdead, 1);
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    cycle(1, 1, 0, 0, '0, 0);
    cycle(1, 0, 0, 1, 64'h5a, 0);
    chk("rst_restart_idx", out_index, 0);
    chk("rst_restart_data", out_data, 64'h5a);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 499) != 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) < 6),
            {$urandom, $urandom}, ($urandom_range(0, 9) < 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
